// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter.
// Scanout reads always own the RAM port. Game writes are queued in a small FIFO
// and retired in cycles the scanout leaves free. A clear engine fills the whole
// buffer with one colour after all previously accepted writes have drained.
module fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FB_WORDS   = 76800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    input  logic                        clear_start,
    input  logic [DATA_W-1:0]           clear_color,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    level_next_s;

    logic [ADDR_W-1:0]   clr_ptr_r;
    logic [ADDR_W-1:0]   clr_ptr_next_s;
    logic [DATA_W-1:0]   clr_color_r;
    logic                busy_r;
    logic                busy_next_s;
    logic                done_r;
    logic                done_next_s;
    logic                rd_valid_r;

    logic                wr_ready_s;
    logic                push_s;
    logic                pop_s;
    logic                clr_write_s;
    logic                clr_last_s;
    logic                accept_s;

    // Handshake and port-ownership qualifiers derived from the current state
    always_comb begin
        wr_ready_s  = (state_r != FLUSH) && (level_r < FULL_LEVEL);
        push_s      = wr_valid && wr_ready_s;
        pop_s       = !rd_req && (state_r != CLEAR) && (level_r != {LVL_W{1'b0}});
        clr_write_s = !rd_req && (state_r == CLEAR);
        clr_last_s  = clr_write_s && (clr_ptr_r == LAST_ADDR);
        accept_s    = (state_r == IDLE) && clear_start;
    end

    // RAM port mux: scanout read, then clear fill, then FIFO head, else parked
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_we    = 1'b0;
        if (rd_req) begin
            mem_addr = rd_addr;
        end else if (state_r == CLEAR) begin
            mem_addr  = clr_ptr_r;
            mem_wdata = clr_color_r;
            mem_we    = 1'b1;
        end else if (pop_s) begin
            mem_addr  = fifo_addr_r[rd_ptr_r];
            mem_wdata = fifo_data_r[rd_ptr_r];
            mem_we    = 1'b1;
        end else begin
            mem_we = 1'b0;
        end
    end

    // FIFO occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Clear FSM next-state, fill pointer and status flags
    always_comb begin
        state_next_s   = state_r;
        clr_ptr_next_s = clr_ptr_r;
        busy_next_s    = busy_r;
        done_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_start) begin
                    state_next_s = FLUSH;
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FLUSH: begin
                if (level_r == {LVL_W{1'b0}}) begin
                    state_next_s   = CLEAR;
                    clr_ptr_next_s = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = FLUSH;
                end
            end
            CLEAR: begin
                if (clr_last_s) begin
                    state_next_s = IDLE;
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                end else if (clr_write_s) begin
                    clr_ptr_next_s = clr_ptr_r + ADDR_W'(1);
                end else begin
                    clr_ptr_next_s = clr_ptr_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Control registers: FSM, FIFO pointers, fill pointer and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            clr_ptr_r   <= {ADDR_W{1'b0}};
            clr_color_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            level_r    <= level_next_s;
            clr_ptr_r  <= clr_ptr_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            rd_valid_r <= rd_req;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (accept_s) begin
                clr_color_r <= clear_color;
            end
        end
    end

    // FIFO payload storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= wr_addr;
            fifo_data_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data    = mem_rdata;
    assign rd_valid   = rd_valid_r;
    assign wr_ready   = wr_ready_s;
    assign clear_busy = busy_r;
    assign clear_done = done_r;
    assign fifo_level = level_r;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter between the VGA scanout path and the game-logic pixel writer. Scanout reads always win. Game writes are buffered in a small FIFO and retired in cycles the scanout leaves free. A built-in clear engine fills the whole buffer with one colour, ordered after all previously accepted writes.

## Interface
Parameters:
- ADDR_W, 17: frame-buffer address width.
- DATA_W, 8: pixel word width.
- FB_WORDS, 76800: number of words the clear engine fills (addresses 0..FB_WORDS-1); must be ≤ 2^ADDR_W.
- FIFO_DEPTH, 4: write FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock (same clock that drives the VGA timing counters).
- rst  in  1  asynchronous, active-low reset.
- rd_req  in  1  scanout read request this cycle.
- rd_addr  in  ADDR_W  scanout read address.
- rd_data  out  DATA_W  read data; combinational copy of mem_rdata.
- rd_valid  out  1  rd_data holds the result of the read requested the previous cycle.
- wr_valid  in  1  game write offered.
- wr_addr  in  ADDR_W  game write address.
- wr_data  in  DATA_W  game write data.
- wr_ready  out  1  FIFO accepts; a write transfers when wr_valid and wr_ready are both high on a clk edge.
- clear_start  in  1  single-cycle clear request.
- clear_color  in  DATA_W  fill value; sampled with clear_start.
- clear_busy  out  1  high from the clear_start acceptance edge until the clear completes.
- clear_done  out  1  one-cycle pulse on completion.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data, valid one clk after address with mem_we=0.

## Operation
- FSM states: IDLE, FLUSH, CLEAR. Reset enters IDLE.
- Per-cycle port owner, highest priority first:
  1. rd_req → read at rd_addr, mem_we=0.
  2. CLEAR → write clear_color at clr_ptr.
  3. FIFO non-empty and state ≠ CLEAR → pop head and write it.
  4. Otherwise mem_we=0, mem_addr=0.
- mem_addr, mem_wdata and mem_we are combinational from rd_req, rd_addr, state and FIFO head.
- wr_ready = (state ≠ FLUSH) && (fifo_level < FIFO_DEPTH).
  - No push when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle leaves fifo_level unchanged.
- IDLE + clear_start → FLUSH. clear_color is latched and clear_busy rises. clear_start is ignored in FLUSH and CLEAR.
- FLUSH: no new writes are accepted; the FIFO drains. When fifo_level==0 at a clk edge → CLEAR with clr_ptr=0. With an empty FIFO at acceptance, FLUSH lasts exactly one cycle.
- CLEAR: each cycle without rd_req writes clr_ptr and increments it. Cycles with rd_req stall clr_ptr.
  - The write to FB_WORDS-1 → IDLE, clear_busy falls, clear_done pulses for one cycle.
  - Game writes accepted during CLEAR stay queued and drain only after IDLE, so they land on top of the fill.
- rd_valid is a register of rd_req.

## Timing
- Reset values:
  - rd_valid=0, clear_busy=0, clear_done=0, fifo_level=0, mem_we=0, wr_ready=1.
  - rd_data follows mem_rdata and is not reset.
- Read latency: rd_req at cycle N → rd_valid and data at cycle N+1. Back-to-back reads are sustained at one per cycle indefinitely.
- Write latency: accepted at edge N. Earliest mem_we is cycle N+1, given no rd_req and no FLUSH/CLEAR hold.
- Clear duration with no reads: 1 (FLUSH) + FB_WORDS cycles from acceptance to clear_done. Each rd_req cycle adds one cycle. Each queued entry at acceptance adds one FLUSH cycle.
- Starvation: continuous rd_req starves writes and clear. The scanout guarantees idle cycles (every second clk, plus blanking).
- Asynchronous reset mid-FLUSH or mid-CLEAR: the FSM aborts to IDLE and the FIFO empties. No clear_done is issued. Memory is left partially written.

## Test plan
- Read latency: rd_req=1, rd_addr=0x00005 for 3 cycles, RAM model word5=0xA3 → rd_valid high on cycles 2–4, rd_data=0xA3, mem_we never high.
- FIFO backpressure: rd_req held 1, 5 writes offered (FIFO_DEPTH=4) → 4 accepted, wr_ready=0 and fifo_level=4. Drop rd_req → 4 writes retire in order on 4 consecutive cycles.
- Priority: rd_req alternating 1/0 with 2 queued writes → writes only on rd_req=0 cycles; rd_valid pattern 1/0 continuous.
- Clear ordering (FB_WORDS=16): queue writes addr3=0x11, addr4=0x22, then clear_start color=0x00, then during CLEAR write addr3=0x77.
  - Expected final RAM: addr3=0x77, addr4=0x00, all others 0x00.
  - clear_done exactly once; total cycles = 2 FLUSH + 1 + 16.
- Clear with read stalls (FB_WORDS=16): rd_req on every other cycle during CLEAR → clear_done 32±1 cycles after entering CLEAR; clear_start pulsed mid-clear is ignored.
- Reset mid-clear: assert rst at clr_ptr=7 → outputs at reset values immediately; addresses ≥7 unchanged; no clear_done.
